// File: rtl/aer_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : aer_tx_scheduler
// Brief    : Round-robin scheduler that feeds per-channel up/down spike events
//            to the AER serial sender and counts receiver acks to find the
//            end of each word. Optional ack watchdog: AER_ACK_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module aer_tx_scheduler #(
    parameter int NUM_CH         = 2,
    parameter int WORD_BITS      = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] ev_up,
    input  logic [NUM_CH-1:0] ev_down,
    input  logic              ack,
    output logic              go,
    output logic [NUM_CH-1:0] ch_sel,
    output logic              up,
    output logic              down,
    output logic              busy,
    output logic              overflow,
    output logic              timeout_err
);

    localparam int c_IDX_W = $clog2(NUM_CH);
    localparam int c_CNT_W = $clog2(WORD_BITS + 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_GO   = 3'd2,
        S_WAIT = 3'd3,
        S_DONE = 3'd4
    } state_t;

    if (NUM_CH < 2 || NUM_CH > 8 || WORD_BITS < 1 || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("aer_tx_scheduler: parameter out of range");
    end

    state_t              r_state, w_state_nxt;
    logic [NUM_CH-1:0]   r_ev_up_q, r_ev_dn_q, r_pend_up, r_pend_dn;
    logic [NUM_CH-1:0]   w_up_rise, w_dn_rise, w_clr_up, w_clr_dn, w_req, w_win_sel;
    logic [c_IDX_W-1:0]  r_ptr, r_cur, w_win_idx;
    logic [c_IDX_W:0]    w_scan;
    logic                w_any_pend, w_win_up;
    logic                r_ack_meta, r_ack_s, r_ack_q, w_ack_edge;
    logic [c_CNT_W-1:0]  r_bitcnt;
    logic                w_word_end, w_tmo;
    logic                r_go, r_busy, r_up, r_down, r_overflow;
    logic [NUM_CH-1:0]   r_ch_sel;

    assign w_up_rise  = ev_up & ~r_ev_up_q;
    assign w_dn_rise  = ev_down & ~r_ev_dn_q;
    assign w_req      = r_pend_up | r_pend_dn;
    assign w_any_pend = |w_req;
    assign w_ack_edge = r_ack_s & ~r_ack_q;
    assign w_word_end = (r_state == S_WAIT) && (r_bitcnt == c_CNT_W'(WORD_BITS)) && !r_ack_s;

    // The served slot is released in DONE; a fresh edge in that same cycle re-arms it.
    assign w_clr_up = (r_state == S_DONE && r_up)   ? r_ch_sel : '0;
    assign w_clr_dn = (r_state == S_DONE && r_down) ? r_ch_sel : '0;

    // Scan from highest rotation offset down so the nearest requester to r_ptr wins.
    always_comb begin
        w_win_idx = r_ptr;
        w_scan    = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            w_scan = {1'b0, r_ptr} + (c_IDX_W + 1)'(k);
            if (w_scan >= (c_IDX_W + 1)'(NUM_CH)) begin
                w_scan = w_scan - (c_IDX_W + 1)'(NUM_CH);
            end
            if (w_req[w_scan[c_IDX_W-1:0]]) begin
                w_win_idx = w_scan[c_IDX_W-1:0];
            end
        end
    end

    assign w_win_up  = r_pend_up[w_win_idx];
    assign w_win_sel = {{(NUM_CH - 1){1'b0}}, 1'b1} << w_win_idx;

`ifdef AER_ACK_TIMEOUT_EN
    localparam int c_TMO_W = $clog2(TIMEOUT_CYCLES);

    logic [c_TMO_W-1:0] r_tmo_cnt;
    logic               r_timeout_err;

    assign w_tmo = (r_state == S_GO || r_state == S_WAIT) && !w_ack_edge &&
                   (r_tmo_cnt == c_TMO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tmo_cnt     <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if ((r_state == S_GO || r_state == S_WAIT) && !w_ack_edge) begin
                r_tmo_cnt <= r_tmo_cnt + 1'b1;
            end else begin
                r_tmo_cnt <= '0;
            end
            if (w_tmo && !w_word_end) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    assign timeout_err = r_timeout_err;
`else
    assign w_tmo       = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_any_pend) w_state_nxt = S_LOAD;
            S_LOAD:  w_state_nxt = S_GO;
            S_GO: begin
                if (w_ack_edge) begin
                    w_state_nxt = S_WAIT;
                end else if (w_tmo) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_WAIT:  if (w_word_end || w_tmo) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ev_up_q  <= '0;
            r_ev_dn_q  <= '0;
            r_pend_up  <= '0;
            r_pend_dn  <= '0;
            r_ptr      <= '0;
            r_cur      <= '0;
            r_ack_meta <= 1'b0;
            r_ack_s    <= 1'b0;
            r_ack_q    <= 1'b0;
            r_bitcnt   <= '0;
            r_go       <= 1'b0;
            r_busy     <= 1'b0;
            r_ch_sel   <= '0;
            r_up       <= 1'b0;
            r_down     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_ev_up_q  <= ev_up;
            r_ev_dn_q  <= ev_down;
            r_ack_meta <= ack;
            r_ack_s    <= r_ack_meta;
            r_ack_q    <= r_ack_s;
            r_pend_up  <= (r_pend_up & ~w_clr_up) | w_up_rise;
            r_pend_dn  <= (r_pend_dn & ~w_clr_dn) | w_dn_rise;
            if (|((r_pend_up & ~w_clr_up & w_up_rise) | (r_pend_dn & ~w_clr_dn & w_dn_rise))) begin
                r_overflow <= 1'b1;
            end
            r_go   <= (w_state_nxt == S_GO);
            r_busy <= (w_state_nxt != S_IDLE);

            if (r_state == S_GO && w_ack_edge) begin
                r_bitcnt <= c_CNT_W'(1);
            end else if (r_state == S_WAIT && w_ack_edge) begin
                r_bitcnt <= r_bitcnt + 1'b1;
            end else if (r_state != S_WAIT) begin
                r_bitcnt <= '0;
            end

            // Winner is latched on entry to LOAD and held untouched until DONE ends.
            if (r_state == S_IDLE && w_any_pend) begin
                r_ch_sel <= w_win_sel;
                r_up     <= w_win_up;
                r_down   <= ~w_win_up;
                r_cur    <= w_win_idx;
            end else if (r_state == S_DONE) begin
                r_ch_sel <= '0;
                r_up     <= 1'b0;
                r_down   <= 1'b0;
                r_ptr    <= (r_cur == c_IDX_W'(NUM_CH - 1)) ? '0 : r_cur + 1'b1;
            end
        end
    end

    assign go       = r_go;
    assign ch_sel   = r_ch_sel;
    assign up       = r_up;
    assign down     = r_down;
    assign busy     = r_busy;
    assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_aer_tx_scheduler.sv
`default_nettype none
// Testbench for aer_tx_scheduler: directed scenarios plus random event bursts
// scored against a pending-slot / round-robin reference model.
module tb_aer_tx_scheduler;

    localparam int NUM_CH         = 2;
    localparam int WORD_BITS      = 8;
    localparam int TIMEOUT_CYCLES = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic [NUM_CH-1:0] ev_up, ev_down;
    logic              ack;
    logic              go, up, down, busy, overflow, timeout_err;
    logic [NUM_CH-1:0] ch_sel;

    int checks = 0;
    int errors = 0;

    // Reference model: one pending flag per (channel, polarity) slot.
    bit m_up [NUM_CH];
    bit m_dn [NUM_CH];
    int m_ptr;
    bit m_ovf;

    aer_tx_scheduler #(
        .NUM_CH        (NUM_CH),
        .WORD_BITS     (WORD_BITS),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ev_up      (ev_up),
        .ev_down    (ev_down),
        .ack        (ack),
        .go         (go),
        .ch_sel     (ch_sel),
        .up         (up),
        .down       (down),
        .busy       (busy),
        .overflow   (overflow),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_up[c] = 1'b0;
            m_dn[c] = 1'b0;
        end
        m_ptr = 0;
        m_ovf = 1'b0;
    endfunction

    function automatic void model_inject(input logic [NUM_CH-1:0] mu, input logic [NUM_CH-1:0] md);
        for (int c = 0; c < NUM_CH; c++) begin
            if (mu[c]) begin
                if (m_up[c]) m_ovf = 1'b1;
                m_up[c] = 1'b1;
            end
            if (md[c]) begin
                if (m_dn[c]) m_ovf = 1'b1;
                m_dn[c] = 1'b1;
            end
        end
    endfunction

    function automatic bit model_any();
        bit a = 1'b0;
        for (int c = 0; c < NUM_CH; c++) a = a | m_up[c] | m_dn[c];
        return a;
    endfunction

    function automatic void model_pick(output int ch, output bit pu);
        ch = -1;
        pu = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            int c = (m_ptr + k) % NUM_CH;
            if (ch < 0 && (m_up[c] || m_dn[c])) begin
                ch = c;
                pu = m_up[c];
            end
        end
    endfunction

    function automatic void model_done(input int ch, input bit pu);
        if (pu) m_up[ch] = 1'b0;
        else    m_dn[ch] = 1'b0;
        m_ptr = (ch + 1) % NUM_CH;
    endfunction

    task automatic pulse_events(input logic [NUM_CH-1:0] mu, input logic [NUM_CH-1:0] md);
        @(negedge clk);
        ev_up   = mu;
        ev_down = md;
        @(negedge clk);
        ev_up   = '0;
        ev_down = '0;
    endtask

    // Waits for go, checks the selected slot, runs one full ack word and checks the release.
    task automatic serve_word(input int exp_ch, input bit exp_up,
                              input logic [NUM_CH-1:0] mid_up, input logic [NUM_CH-1:0] mid_dn);
        logic [NUM_CH-1:0] exp_sel;
        bit                hold_ok;
        int                t;
        exp_sel         = '0;
        exp_sel[exp_ch] = 1'b1;
        t = 0;
        while (go !== 1'b1 && t < 40) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (go !== 1'b1) begin
            errors++;
            $display("FAIL word_go_start: go=%b, required 1 within 40 cycles", go);
        end
        checks++;
        if (ch_sel !== exp_sel || up !== exp_up || down !== ~exp_up || busy !== 1'b1) begin
            errors++;
            $display("FAIL word_select: ch_sel=%b up=%b down=%b busy=%b, required ch_sel=%b up=%b down=%b busy=1",
                     ch_sel, up, down, busy, exp_sel, exp_up, ~exp_up);
        end
        hold_ok = 1'b1;
        for (int b = 0; b < WORD_BITS; b++) begin
            ack = 1'b1;
            for (int h = 0; h < 6; h++) begin
                @(negedge clk);
                if (b == 2 && h == 0) begin
                    ev_up   = mid_up;
                    ev_down = mid_dn;
                end else if (b == 2 && h == 1) begin
                    ev_up   = '0;
                    ev_down = '0;
                end
                if (b == 0 && h == 1) begin
                    checks++;
                    if (go !== 1'b1) begin
                        errors++;
                        $display("FAIL word_go_before_ack: go=%b, required 1", go);
                    end
                end else if (b == 0 && h == 2) begin
                    checks++;
                    if (go !== 1'b0) begin
                        errors++;
                        $display("FAIL word_go_fall: go=%b, required 0 after first ack edge", go);
                    end
                end else if (go !== 1'b0 && !(b == 0 && h == 0)) begin
                    hold_ok = 1'b0;
                end
                if (ch_sel !== exp_sel || up !== exp_up || down !== ~exp_up || busy !== 1'b1) hold_ok = 1'b0;
                if (h == 2) ack = 1'b0;
            end
        end
        checks++;
        if (!hold_ok) begin
            errors++;
            $display("FAIL word_hold: ch_sel=%b up=%b down=%b busy=%b go=%b, required stable selection for whole word",
                     ch_sel, up, down, busy, go);
        end
        t = 0;
        while (busy !== 1'b0 && t < 10) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (busy !== 1'b0 || ch_sel !== '0 || up !== 1'b0 || down !== 1'b0 || go !== 1'b0) begin
            errors++;
            $display("FAIL word_release: busy=%b ch_sel=%b up=%b down=%b go=%b, required all 0 within 10 cycles",
                     busy, ch_sel, up, down, go);
        end
    endtask

    task automatic test_reset();
        bit quiet = 1'b1;
        reset   = 1'b1;
        ev_up   = '0;
        ev_down = '0;
        ack     = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({go, ch_sel, up, down, busy, overflow, timeout_err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: go=%b ch_sel=%b up=%b down=%b busy=%b ovf=%b tmo=%b, required all 0",
                     go, ch_sel, up, down, busy, overflow, timeout_err);
        end
        reset = 1'b0;
        model_reset();
        repeat (5) begin
            @(negedge clk);
            if (busy !== 1'b0 || go !== 1'b0) quiet = 1'b0;
        end
        checks++;
        if (!quiet) begin
            errors++;
            $display("FAIL reset_idle: busy=%b go=%b, required idle with no events", busy, go);
        end
    endtask

    task automatic test_single_event();
        pulse_events('0, 2'b10);
        checks++;
        if (busy !== 1'b0 || go !== 1'b0) begin
            errors++;
            $display("FAIL single_pending: busy=%b go=%b, required 0 0", busy, go);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || go !== 1'b0 || ch_sel !== 2'b10 || down !== 1'b1 || up !== 1'b0) begin
            errors++;
            $display("FAIL single_load: busy=%b go=%b ch_sel=%b up=%b down=%b, required 1 0 10 0 1",
                     busy, go, ch_sel, up, down);
        end
        @(negedge clk);
        checks++;
        if (go !== 1'b1) begin
            errors++;
            $display("FAIL single_go_latency: go=%b, required 1 three clocks after the event", go);
        end
        serve_word(1, 1'b0, '0, '0);
    endtask

    task automatic test_round_robin();
        bit quiet = 1'b1;
        pulse_events(2'b11, '0);
        serve_word(0, 1'b1, '0, '0);
        serve_word(1, 1'b1, 2'b01, '0);
        serve_word(0, 1'b1, '0, '0);
        repeat (20) begin
            @(negedge clk);
            if (busy !== 1'b0 || go !== 1'b0) quiet = 1'b0;
        end
        checks++;
        if (!quiet) begin
            errors++;
            $display("FAIL rr_extra_word: busy=%b go=%b, required no fourth word", busy, go);
        end
    endtask

    task automatic test_same_channel();
        pulse_events(2'b01, 2'b01);
        serve_word(0, 1'b1, '0, '0);
        serve_word(0, 1'b0, '0, '0);
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL same_ch_overflow: overflow=%b, required 0", overflow);
        end
    endtask

    task automatic test_overflow();
        bit quiet = 1'b1;
        pulse_events(2'b10, '0);
        pulse_events(2'b10, '0);
        serve_word(1, 1'b1, '0, '0);
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_flag: overflow=%b, required 1", overflow);
        end
        repeat (20) begin
            @(negedge clk);
            if (busy !== 1'b0 || go !== 1'b0) quiet = 1'b0;
        end
        checks++;
        if (!quiet) begin
            errors++;
            $display("FAIL ovf_single_word: busy=%b go=%b, required merged event to send one word", busy, go);
        end
    endtask

    task automatic test_reset_mid_word();
        bit quiet = 1'b1;
        int t = 0;
        pulse_events(2'b01, '0);
        while (go !== 1'b1 && t < 40) begin
            @(negedge clk);
            t++;
        end
        repeat (3) begin
            ack = 1'b1;
            repeat (3) @(negedge clk);
            ack = 1'b0;
            repeat (3) @(negedge clk);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (go !== 1'b0 || ch_sel !== '0 || busy !== 1'b0 || up !== 1'b0 || down !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL midword_reset: go=%b ch_sel=%b busy=%b up=%b down=%b ovf=%b, required all 0",
                     go, ch_sel, busy, up, down, overflow);
        end
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        repeat (30) begin
            @(negedge clk);
            if (busy !== 1'b0 || go !== 1'b0) quiet = 1'b0;
        end
        checks++;
        if (!quiet) begin
            errors++;
            $display("FAIL midword_no_resend: busy=%b go=%b, required no word after reset", busy, go);
        end
    endtask

    task automatic test_random();
        logic [NUM_CH-1:0] mu, md, iu, id;
        int                ch, guard;
        bit                pu;
        bit                quiet = 1'b1;
        for (int r = 0; r < 8; r++) begin
            mu = NUM_CH'($urandom());
            md = NUM_CH'($urandom());
            if ((mu | md) == '0) mu[0] = 1'b1;
            model_inject(mu, md);
            pulse_events(mu, md);
            guard = 0;
            while (model_any() && guard < 16) begin
                model_pick(ch, pu);
                if ($urandom_range(0, 2) == 0) begin
                    iu = NUM_CH'($urandom());
                    id = NUM_CH'($urandom());
                end else begin
                    iu = '0;
                    id = '0;
                end
                model_inject(iu, id);
                serve_word(ch, pu, iu, id);
                model_done(ch, pu);
                guard++;
            end
            checks++;
            if (overflow !== m_ovf) begin
                errors++;
                $display("FAIL rand_overflow: round %0d overflow=%b, required %b", r, overflow, m_ovf);
            end
        end
        repeat (20) begin
            @(negedge clk);
            if (busy !== 1'b0 || go !== 1'b0) quiet = 1'b0;
        end
        checks++;
        if (!quiet) begin
            errors++;
            $display("FAIL rand_drain: busy=%b go=%b, required idle once all slots served", busy, go);
        end
    endtask

    task automatic test_ack_stall();
        int t = 0;
        bit ok = 1'b1;
        pulse_events(2'b01, '0);
        while (go !== 1'b1 && t < 40) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (go !== 1'b1) begin
            errors++;
            $display("FAIL stall_go_start: go=%b, required 1", go);
        end
`ifdef AER_ACK_TIMEOUT_EN
        t = 1;
        while (go === 1'b1 && t < 100) begin
            @(negedge clk);
            if (go === 1'b1) t++;
        end
        checks++;
        if (t != TIMEOUT_CYCLES) begin
            errors++;
            $display("FAIL stall_go_width: go high %0d cycles, required %0d", t, TIMEOUT_CYCLES);
        end
        checks++;
        if (timeout_err !== 1'b1) begin
            errors++;
            $display("FAIL stall_timeout_err: timeout_err=%b, required 1", timeout_err);
        end
        repeat (20) begin
            @(negedge clk);
            if (busy !== 1'b0 || go !== 1'b0) ok = 1'b0;
        end
        checks++;
        if (!ok || timeout_err !== 1'b1) begin
            errors++;
            $display("FAIL stall_discard: busy=%b go=%b timeout_err=%b, required idle, slot dropped, error sticky",
                     busy, go, timeout_err);
        end
`else
        repeat (40) begin
            @(negedge clk);
            if (go !== 1'b1 || busy !== 1'b1 || timeout_err !== 1'b0) ok = 1'b0;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL stall_wait: go=%b busy=%b timeout_err=%b, required 1 1 0 while ack stalls",
                     go, busy, timeout_err);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (go !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL stall_recover: go=%b busy=%b, required 0 0 after reset", go, busy);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_single_event();
        test_round_robin();
        test_same_channel();
        test_overflow();
        test_reset_mid_word();
        test_random();
        test_ack_stall();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation still running, required completion within time limit");
        $fatal(1, "time limit reached");
    end

endmodule
`default_nettype wire
